// File: rtl/dmem_wb_master.sv
// Data-memory bus master: turns a one-cycle memory-stage request into a single
// Wishbone B4 pipelined transaction, with a bus-hang timeout and a registered completion.
module dmem_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_wen_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_strb_i,
  output logic        req_done_o,
  output logic [31:0] req_rdata_o,
  output logic        req_err_o,
  output logic        busy_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic [3:0]        sel_q, sel_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              bus_resp;
  logic              tmo_hit;

  assign bus_resp = cyc_q & (wb_ack_i | wb_err_i);
  assign tmo_hit  = TMO_EN && (cnt_q == CNT_MAX);

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path through
    // this block leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          adr_d   = req_addr_i;
          we_d    = req_wen_i;
          dat_d   = req_wdata_i;
          sel_d   = req_wen_i ? req_strb_i : 4'hF;
          cnt_d   = '0;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = ST_REQ;
        end
      end

      ST_REQ, ST_WAIT: begin
        if (bus_resp) begin
          // ack+err together is reported as an error and discards the data
          done_d  = 1'b1;
          err_d   = wb_err_i;
          rdata_d = (!we_q && !wb_err_i) ? wb_dat_i : 32'h0;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = 32'h0;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          // The counter stops at CNT_MAX by leaving the state, so it never wraps
          if (TMO_EN) cnt_d = cnt_q + CNT_W'(1);
          if (state_q == ST_REQ && !wb_stall_i) begin
            stb_d   = 1'b0;
            state_d = ST_WAIT;
          end
        end
      end

      default: begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 32'h0;
      dat_q   <= 32'h0;
      sel_q   <= 4'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // cyc is high exactly in REQ and WAIT, so it doubles as the busy flag
  assign busy_o      = cyc_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;
  assign req_done_o  = done_q;
  assign req_err_o   = err_q;
  assign req_rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_wb_master.sv
// Directed bench for dmem_wb_master: table-driven single transactions on a default
// instance, plus hand sequences for back-to-back, reset and timeout (TIMEOUT_CYCLES=4).
module tb_dmem_wb_master;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        req_valid, req_wen, req_done, req_err, busy;
  logic [31:0] req_addr, req_wdata, req_rdata;
  logic [3:0]  req_strb;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err, wb_stall;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;

  logic        t_req_valid, t_req_done, t_req_err, t_busy;
  logic [31:0] t_req_rdata;
  logic        t_wb_cyc, t_wb_stb, t_wb_we, t_wb_ack;
  logic [31:0] t_wb_adr, t_wb_dat_o, t_wb_dat_i;
  logic [3:0]  t_wb_sel;

  dmem_wb_master dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_wen_i(req_wen), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .req_done_o(req_done), .req_rdata_o(req_rdata), .req_err_o(req_err), .busy_o(busy),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_stall_i(wb_stall)
  );

  dmem_wb_master #(.TIMEOUT_CYCLES(4)) dut_tmo (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(t_req_valid), .req_wen_i(1'b0), .req_addr_i(32'h0000_0500),
    .req_wdata_i(32'h0), .req_strb_i(4'h0),
    .req_done_o(t_req_done), .req_rdata_o(t_req_rdata), .req_err_o(t_req_err), .busy_o(t_busy),
    .wb_cyc_o(t_wb_cyc), .wb_stb_o(t_wb_stb), .wb_we_o(t_wb_we),
    .wb_adr_o(t_wb_adr), .wb_dat_o(t_wb_dat_o), .wb_sel_o(t_wb_sel),
    .wb_dat_i(t_wb_dat_i), .wb_ack_i(t_wb_ack), .wb_err_i(1'b0), .wb_stall_i(1'b0)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        ack;
    logic        err;
    logic [31:0] rsp;
    int          stall;
    int          wt;
    logic [3:0]  exp_sel;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    int   n;
    logic early, stable;
    req_wen   = v.wen;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_strb  = v.strb;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = ~v.wdata;
    req_strb  = ~v.strb;
    n = 0; early = 1'b0; stable = 1'b1;
    check("stb_rise", {31'b0, wb_stb}, 32'd1);
    check("busy", {31'b0, busy}, 32'd1);
    check("adr", wb_adr, v.addr);
    check("we", {31'b0, wb_we}, {31'b0, v.wen});
    check("sel", {28'b0, wb_sel}, {28'b0, v.exp_sel});
    if (v.wen) check("dat", wb_dat_o, v.wdata);
    for (int i = 0; i < v.stall; i++) begin
      wb_stall = 1'b1;
      tick(); n++;
      early  |= req_done;
      stable &= (wb_stb && wb_adr == v.addr && wb_sel == v.exp_sel && wb_dat_o == v.wdata);
    end
    if (v.stall > 0) check("stall_stable", {31'b0, stable}, 32'd1);
    wb_stall = 1'b0;
    if (v.wt > 0) begin
      tick(); n++;
      early |= req_done;
      check("stb_drop", {30'b0, wb_cyc, wb_stb}, 32'd2);
      for (int i = 1; i < v.wt; i++) begin
        tick(); n++;
        early |= req_done;
      end
    end
    wb_ack = v.ack; wb_err = v.err; wb_dat_i = v.rsp;
    tick(); n++;
    wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = 32'hA5A5_A5A5;
    check("no_early_done", {31'b0, early}, 32'd0);
    check("done", {31'b0, req_done}, 32'd1);
    check("latency", n + 1, v.exp_lat);
    check("err", {31'b0, req_err}, {31'b0, v.exp_err});
    check("rdata", req_rdata, v.exp_rdata);
    check("cyc_stb_drop", {30'b0, wb_cyc, wb_stb}, 32'd0);
    tick();
    check("done_pulse", {31'b0, req_done}, 32'd0);
    check("rdata_hold", req_rdata, v.exp_rdata);
  endtask

  initial begin
    int n;
    //           wen   addr          wdata         strb   ack   err   rsp           st wt sel    rdata         err  lat
    vecs[0] = '{1'b0, 32'h0000_0100, 32'h0,        4'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 0, 0, 4'hF, 32'hDEAD_BEEF, 1'b0, 2};
    vecs[1] = '{1'b1, 32'h0000_0204, 32'h0000_ABCD, 4'h3, 1'b1, 1'b0, 32'h55AA_55AA, 3, 2, 4'h3, 32'h0,         1'b0, 7};
    vecs[2] = '{1'b0, 32'h0000_0300, 32'h0,        4'h0, 1'b0, 1'b1, 32'h1234_5678, 0, 1, 4'hF, 32'h0,         1'b1, 3};
    vecs[3] = '{1'b0, 32'h0000_040C, 32'h0,        4'h5, 1'b1, 1'b0, 32'hCAFE_F00D, 1, 0, 4'hF, 32'hCAFE_F00D, 1'b0, 3};
    vecs[4] = '{1'b1, 32'h0000_0410, 32'h1122_0000, 4'hC, 1'b1, 1'b0, 32'h7777_7777, 0, 3, 4'hC, 32'h0,         1'b0, 5};
    vecs[5] = '{1'b0, 32'h0000_0414, 32'h0,        4'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 0, 0, 4'hF, 32'h0,         1'b1, 2};

    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_strb = 4'h0;
    wb_dat_i = 32'h0; wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
    t_req_valid = 1'b0; t_wb_ack = 1'b0; t_wb_dat_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {26'b0, req_done, req_err, busy, wb_cyc, wb_stb, wb_we}, 32'd0);
    check("rst_rdata", req_rdata, 32'h0);
    check("rst_bus", wb_adr | wb_dat_o | {28'b0, wb_sel}, 32'h0);
    check("rst_tmo_inst", {29'b0, t_wb_cyc, t_wb_stb, t_req_done}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Stray ack/err while idle must not produce a completion
    wb_ack = 1'b1; wb_err = 1'b1;
    tick(); tick();
    wb_ack = 1'b0; wb_err = 1'b0;
    check("stray_ack", {30'b0, req_done, wb_cyc}, 32'd0);

    // Back-to-back: new request in the done cycle; a request during WAIT is dropped
    req_wen = 1'b0; req_addr = 32'h0000_0600; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; wb_ack = 1'b1; wb_dat_i = 32'h600D_0001;
    tick();
    wb_ack = 1'b0;
    check("b2b_done1", {31'b0, req_done}, 32'd1);
    check("b2b_rdata1", req_rdata, 32'h600D_0001);
    req_addr = 32'h0000_0604; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("b2b_stb2", {31'b0, wb_stb}, 32'd1);
    check("b2b_adr2", wb_adr, 32'h0000_0604);
    tick();
    check("b2b_wait", {30'b0, wb_cyc, wb_stb}, 32'd2);
    req_wen = 1'b1; req_addr = 32'h0000_0700; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("ignored_adr", wb_adr, 32'h0000_0604);
    check("ignored_state", {29'b0, wb_we, wb_cyc, wb_stb}, 32'd2);
    wb_ack = 1'b1; wb_dat_i = 32'h0BAD_F00D;
    tick();
    wb_ack = 1'b0;
    check("b2b_done2", {31'b0, req_done}, 32'd1);
    check("b2b_rdata2", req_rdata, 32'h0BAD_F00D);
    tick();
    check("no_extra_txn", {29'b0, wb_cyc, wb_stb, req_done}, 32'd0);

    // Reset while in WAIT
    req_wen = 1'b1; req_addr = 32'h0000_0800; req_wdata = 32'h1; req_strb = 4'hF; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("pre_rst_wait", {30'b0, wb_cyc, wb_stb}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("rst_async_ctrl", {27'b0, req_done, req_err, busy, wb_cyc, wb_stb}, 32'd0);
    check("rst_async_rdata", req_rdata, 32'h0);
    check("rst_async_bus", wb_adr | wb_dat_o | {28'b0, wb_sel}, 32'h0);
    wb_ack = 1'b1;
    tick();
    rst = 1'b0; wb_ack = 1'b0;
    tick();
    check("rst_no_done", {31'b0, req_done}, 32'd0);
    run_txn(vecs[0]);

    // Timeout instance: a normal load first, then a silent slave
    t_req_valid = 1'b1;
    tick();
    t_req_valid = 1'b0; t_wb_ack = 1'b1; t_wb_dat_i = 32'h1111_2222;
    tick();
    t_wb_ack = 1'b0;
    check("t_load_done", {31'b0, t_req_done}, 32'd1);
    check("t_load_rdata", t_req_rdata, 32'h1111_2222);
    tick();
    t_req_valid = 1'b1;
    tick();
    t_req_valid = 1'b0;
    check("t_stb_rise", {31'b0, t_wb_stb}, 32'd1);
    n = 0;
    while (!t_req_done && n < 20) begin
      tick();
      n++;
    end
    check("tmo_latency", n, 32'd5);
    check("tmo_err", {31'b0, t_req_err}, 32'd1);
    check("tmo_rdata", t_req_rdata, 32'h0);
    check("tmo_cyc", {30'b0, t_wb_cyc, t_busy}, 32'd0);
    t_wb_ack = 1'b1;
    tick();
    t_wb_ack = 1'b0;
    check("tmo_late_ack", {30'b0, t_req_done, t_wb_cyc}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
